// File: rtl/alu_cmd_issuer.sv
// Initiator for the combinational ALU: accepts a tagged command, drives the
// ALU operands/control, waits a settle time and returns the sampled result.
module alu_cmd_issuer #(
  parameter int PART_LEN      = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int TAG_W         = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [2*PART_LEN-1:0] cmd_a,
  input  logic [2*PART_LEN-1:0] cmd_b,
  input  logic [TAG_W-1:0]      cmd_tag,
  output logic [2*PART_LEN-1:0] alu_a,
  output logic [2*PART_LEN-1:0] alu_b,
  output logic [1:0]            alu_ctrl,
  input  logic [2*PART_LEN-1:0] alu_res,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*PART_LEN-1:0] rsp_res,
  output logic [TAG_W-1:0]      rsp_tag,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int W = 2*PART_LEN;
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_cnt;
  logic [W-1:0]     r_alu_a;
  logic [W-1:0]     r_alu_b;
  logic [1:0]       r_alu_ctrl;
  logic [TAG_W-1:0] r_tag;
  logic             r_rsp_valid;
  logic [W-1:0]     r_rsp_res;
  logic [TAG_W-1:0] r_rsp_tag;
  logic             r_rsp_err;
  logic [1:0]       w_ctrl;
  logic             w_rsvd;
  logic             w_accept;

  assign w_rsvd   = (cmd_op == 2'b11);
  assign w_accept = cmd_valid && (r_state == IDLE);

  // Reserved opcode keeps the previously issued control
  always_comb begin
    w_ctrl = r_alu_ctrl;
    unique case (1'b1)
      (cmd_op == 2'b00): w_ctrl = 2'b10;
      (cmd_op == 2'b01): w_ctrl = 2'b11;
      (cmd_op == 2'b10): w_ctrl = 2'b00;
      default:           w_ctrl = r_alu_ctrl;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_next = w_rsvd ? RESP : SETTLE;
      end
      SETTLE: begin
        if (r_cnt == 4'd0) w_next = RESP;
      end
      RESP: begin
        if (r_rsp_valid && rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_ctrl  <= '0;
      r_tag       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_res   <= '0;
      r_rsp_tag   <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_alu_a    <= cmd_a;
            r_alu_b    <= cmd_b;
            r_alu_ctrl <= w_ctrl;
            r_tag      <= cmd_tag;
            if (w_rsvd) begin
              r_rsp_res <= '0;
              r_rsp_err <= 1'b1;
              r_rsp_tag <= cmd_tag;
            end else begin
              r_cnt <= CNT_LOAD;
            end
          end
        end
        SETTLE: begin
          if (r_cnt == 4'd0) begin
            r_rsp_res   <= alu_res;
            r_rsp_err   <= 1'b0;
            r_rsp_tag   <= r_tag;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          // Error responses enter RESP one edge before valid rises
          if (!r_rsp_valid)    r_rsp_valid <= 1'b1;
          else if (rsp_ready)  r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_ctrl  = r_alu_ctrl;
  assign rsp_valid = r_rsp_valid;
  assign rsp_res   = r_rsp_res;
  assign rsp_tag   = r_rsp_tag;
  assign rsp_err   = r_rsp_err;

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Initiator side of the ALU operand/control interface.
- Accepts tagged arithmetic commands over a valid/ready handshake and drives the ALU's a, b and control_sig inputs.
- Waits a fixed settle time, captures the ALU result and returns it with the command tag over a second valid/ready handshake.
- Sits between the command source (testbench or datapath controller) and the combinational ALU; exactly one command is in flight at a time.

Parameters:
- PART_LEN, 8, half-operand width; operand and result width is 2*PART_LEN.
- SETTLE_CYCLES, 2, clock edges from command accept to result sample; legal range 1 to 15.
- TAG_W, 4, width of the command/response tag.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  synchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  issuer can accept a command.
- cmd_op  in  2  operation: 00 ADD, 01 SUB, 10 MUL, 11 reserved.
- cmd_a  in  2*PART_LEN  operand A.
- cmd_b  in  2*PART_LEN  operand B.
- cmd_tag  in  TAG_W  command identifier, echoed on the response.
- alu_a  out  2*PART_LEN  to ALU a.
- alu_b  out  2*PART_LEN  to ALU b.
- alu_ctrl  out  2  to ALU control_sig; bit1 = opp, bit0 = asn.
- alu_res  in  2*PART_LEN  from ALU res.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_res  out  2*PART_LEN  captured result.
- rsp_tag  out  TAG_W  echoed tag.
- rsp_err  out  1  reserved opcode was issued.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (rstn low at a clk edge):
  - State goes to IDLE.
  - alu_a, alu_b, rsp_res, rsp_tag = 0; alu_ctrl = 00.
  - rsp_valid, rsp_err, busy = 0; settle counter = 0.
  - cmd_ready is 1 in the first cycle after reset.
- Opcode mapping to alu_ctrl: ADD -> 10, SUB -> 11, MUL -> 00. The reserved opcode leaves alu_ctrl unchanged.
- cmd_ready = (state == IDLE), driven combinationally from state only.
- IDLE:
  - On the edge where cmd_valid and cmd_ready are both high, register cmd_a/cmd_b into alu_a/alu_b, register the mapped alu_ctrl, and latch cmd_tag.
  - For ADD, SUB or MUL: load counter = SETTLE_CYCLES - 1 and go to SETTLE.
  - For the reserved opcode: set rsp_res = 0 and rsp_err = 1, then go to RESP directly. rsp_valid is high after the next edge.
- SETTLE:
  - Decrement the counter each edge.
  - On the edge where the counter equals 0: rsp_res <= alu_res, rsp_err <= 0, rsp_tag <= latched tag, rsp_valid <= 1, go to RESP.
  - Net effect: a command accepted at edge k is sampled and presented at edge k+SETTLE_CYCLES.
- RESP:
  - rsp_valid, rsp_res, rsp_tag and rsp_err hold stable until rsp_valid and rsp_ready are both high at an edge.
  - On that edge, rsp_valid <= 0 and the state returns to IDLE.
  - A command cannot be accepted on that same edge; minimum spacing is SETTLE_CYCLES+2 edges per command.
- alu_a, alu_b and alu_ctrl hold their last issued values in every state; they change only on accept or reset.
- cmd_valid while not IDLE is ignored: no state change, and the command is not lost because cmd_ready is low.
- Reset mid-operation (SETTLE or RESP): the in-flight command is discarded and no response is produced.
- rsp_ready high while rsp_valid is low has no effect.
- Widths: results are the raw 2*PART_LEN-bit ALU output. No overflow or sign handling is done in this block.

Test Plan (PART_LEN=8, SETTLE_CYCLES=2, behavioural ALU model on alu_*, rsp_ready held high unless stated):
- ADD, a=0x1234, b=0x0101, tag=3, accepted at edge k:
  - alu_ctrl=10 after edge k.
  - rsp_valid=1 after edge k+2, with rsp_res=0x1335, rsp_tag=3, rsp_err=0.
  - IDLE again after edge k+3.
- SUB, a=0x0010, b=0x0001, tag=5: alu_ctrl=11; response rsp_res=0x000F, tag=5.
- MUL, a=0x0012, b=0x0003, tag=7:
  - alu_ctrl=00; rsp_res=0x0036.
  - A second cmd_valid with tag=8, asserted during SETTLE, is not accepted until the tag-7 response handshakes.
- Backpressure: rsp_ready held low for 5 cycles after rsp_valid rises.
  - rsp_valid, rsp_res, rsp_tag, alu_a, alu_b and alu_ctrl stay stable; cmd_ready=0 and busy=1 throughout.
  - Returns to IDLE one edge after rsp_ready rises.
- Reserved opcode 11, tag=2:
  - rsp_valid=1 after edge k+1, with rsp_err=1, rsp_res=0x0000, tag=2.
  - alu_ctrl keeps its previous value.
- Reset: rstn low for one edge during SETTLE of an ADD.
  - All outputs return to reset values and no response appears.
  - A following MUL 0x0002*0x0004 returns 0x0008 normally.
